// File: rtl/rx_integ_dump_pkg.sv
// Shared constants, register field layout and config decode for the
// four-channel integrate-and-dump decimator.
package rx_pkg;

   localparam int NUM_LANES = 4;
   localparam int SMP_W     = 16;
   localparam int ACC_W_DEF = 24;           // 16 + log2(256): a full window cannot overflow

   localparam logic [6:0] REG_ADDR_DEF = 7'd40;

   // control register field positions
   localparam int DM1_LSB   = 0;            // decimation minus one, 8 bits
   localparam int SHIFT_LSB = 8;            // output shift, 5 bits
   localparam int MASK_LSB  = 16;           // channel enable mask, 4 bits

   localparam logic [3:0] SHIFT_MAX = 4'd8;

   // saturation limits of the 16-bit output samples
   localparam int SAT_MAX = 32767;
   localparam int SAT_MIN = -32768;
   localparam logic [SMP_W-1:0] SMP_MAX = 16'h7fff;
   localparam logic [SMP_W-1:0] SMP_MIN = 16'h8000;

   typedef struct packed {
      logic [7:0]           dm1;
      logic [3:0]           shift;
      logic [NUM_LANES-1:0] mask;
   } cfg_t;

   localparam cfg_t CFG_RST = '{dm1: 8'd0, shift: 4'd0, mask: '0};

   // Pull the live fields out of a register write; shifts beyond 8 clamp to 8.
   function automatic cfg_t decode_cfg(input logic [31:0] d);
      cfg_t c;
      c.dm1   = d[DM1_LSB +: 8];
      c.shift = (d[SHIFT_LSB +: 5] > 5'(SHIFT_MAX)) ? SHIFT_MAX : d[SHIFT_LSB +: 4];
      c.mask  = d[MASK_LSB +: NUM_LANES];
      return c;
   endfunction

endpackage

// File: rtl/rx_integ_dump_if.sv
// Serial register bus carrying decimation, shift and channel mask writes.
interface rx_integ_dump_if;
   logic [6:0]  serial_addr;
   logic [31:0] serial_data;
   logic        serial_strobe;

   modport master (output serial_addr, output serial_data, output serial_strobe);
   modport slave  (input  serial_addr, input  serial_data, input  serial_strobe);
endinterface

// File: rtl/rx_shift_sat.sv
// Combinational per-lane arithmetic right shift of an accumulator followed by
// saturation to a signed 16-bit sample; clip_o marks a clipped result.
module rx_shift_sat
   import rx_pkg::*;
#(
   parameter int ACC_W = ACC_W_DEF
) (
   input  logic signed [ACC_W-1:0] acc_i,
   input  logic        [3:0]       shift_i,
   output logic signed [SMP_W-1:0] smp_o,
   output logic                    clip_o
);

   localparam logic signed [ACC_W-1:0] MAX_V = ACC_W'(SAT_MAX);
   localparam logic signed [ACC_W-1:0] MIN_V = ACC_W'(SAT_MIN);

   logic signed [ACC_W-1:0] shd;

   // floor-shift then clamp into the 16-bit range
   always_comb begin
      shd    = acc_i >>> shift_i;
      smp_o  = shd[SMP_W-1:0];
      clip_o = 1'b0;
      if (shd > MAX_V) begin
         smp_o  = SMP_MAX;
         clip_o = 1'b1;
      end else if (shd < MIN_V) begin
         smp_o  = SMP_MIN;
         clip_o = 1'b1;
      end
   end

endmodule

// File: rtl/rx_integ_dump.sv
// Four-channel integrate-and-dump decimator: accumulates D strobed samples per
// enabled channel, then emits sat16(sum >>> S) with a one-cycle rxstrobe.
module rx_integ_dump
   import rx_pkg::*;
#(
   parameter logic [6:0] REG_ADDR = REG_ADDR_DEF,
   parameter int         ACC_W    = ACC_W_DEF
) (
   input  logic                    rxclk,
   input  logic                    reset,
   input  logic                    adc_strobe,
   input  logic signed [SMP_W-1:0] adc_0,
   input  logic signed [SMP_W-1:0] adc_1,
   input  logic signed [SMP_W-1:0] adc_2,
   input  logic signed [SMP_W-1:0] adc_3,
   rx_integ_dump_if.slave          ser,
   input  logic                    clear_status,
   output logic                    rxstrobe,
   output logic [NUM_LANES-1:0]    channels,
   output logic signed [SMP_W-1:0] ch_0,
   output logic signed [SMP_W-1:0] ch_1,
   output logic signed [SMP_W-1:0] ch_2,
   output logic signed [SMP_W-1:0] ch_3,
   output logic                    sat_flag,
   output logic [31:0]             debugbus
);

   cfg_t                                cfg_q, cfg_d;
   logic [7:0]                          cnt_q, cnt_d;
   logic [NUM_LANES-1:0][ACC_W-1:0]     acc_q, acc_d, acc_nxt;
   logic [NUM_LANES-1:0][SMP_W-1:0]     ch_q, ch_d;
   logic [NUM_LANES-1:0][SMP_W-1:0]     adc_v, sat_smp;
   logic [NUM_LANES-1:0]                clip;
   logic                                rxstrobe_q, rxstrobe_d;
   logic                                sat_flag_q, sat_flag_d;
   logic                                reg_wr, smp_en, dump, sat_set;

   assign adc_v = {adc_3, adc_2, adc_1, adc_0};

   // a write wins over a coincident sample; an all-off mask freezes the window
   assign reg_wr = ser.serial_strobe && (ser.serial_addr == REG_ADDR);
   assign smp_en = adc_strobe && !reg_wr && (|cfg_q.mask);
   assign dump   = smp_en && (cnt_q == cfg_q.dm1);

   // running sum including the current sample; restarts at window start
   always_comb begin
      acc_nxt = '0;
      for (int k = 0; k < NUM_LANES; k++) begin
         if (cfg_q.mask[k])
            acc_nxt[k] = ((cnt_q == 8'd0) ? '0 : acc_q[k])
                       + {{(ACC_W-SMP_W){adc_v[k][SMP_W-1]}}, adc_v[k]};
      end
   end

   for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
      rx_shift_sat #(.ACC_W(ACC_W)) u_shift_sat (
         .acc_i   (acc_nxt[g]),
         .shift_i (cfg_q.shift),
         .smp_o   (sat_smp[g]),
         .clip_o  (clip[g])
      );
   end

   // register decode, window counter and accumulator update
   always_comb begin
      cfg_d = cfg_q;
      cnt_d = cnt_q;
      acc_d = acc_q;
      if (reg_wr) begin
         cfg_d = decode_cfg(ser.serial_data);
         cnt_d = '0;
         acc_d = '0;
      end else if (smp_en) begin
         acc_d = acc_nxt;
         cnt_d = dump ? 8'd0 : cnt_q + 8'd1;
      end
   end

   // output sample registers and valid pulse on a dump
   always_comb begin
      ch_d       = ch_q;
      rxstrobe_d = 1'b0;
      sat_set    = 1'b0;
      if (dump) begin
         rxstrobe_d = 1'b1;
         sat_set    = |(clip & cfg_q.mask);
         for (int k = 0; k < NUM_LANES; k++)
            ch_d[k] = cfg_q.mask[k] ? sat_smp[k] : '0;
      end
   end

   // sticky saturation flag; a new clip beats a coincident clear
   always_comb begin
      sat_flag_d = sat_set | (sat_flag_q & ~clear_status);
   end

   // state registers
   always_ff @(posedge rxclk) begin
      if (reset) begin
         cfg_q      <= CFG_RST;
         cnt_q      <= '0;
         acc_q      <= '0;
         ch_q       <= '0;
         rxstrobe_q <= 1'b0;
         sat_flag_q <= 1'b0;
      end else begin
         cfg_q      <= cfg_d;
         cnt_q      <= cnt_d;
         acc_q      <= acc_d;
         ch_q       <= ch_d;
         rxstrobe_q <= rxstrobe_d;
         sat_flag_q <= sat_flag_d;
      end
   end

   assign rxstrobe = rxstrobe_q;
   assign channels = cfg_q.mask;
   assign ch_0     = ch_q[0];
   assign ch_1     = ch_q[1];
   assign ch_2     = ch_q[2];
   assign ch_3     = ch_q[3];
   assign sat_flag = sat_flag_q;
   assign debugbus = {21'd0, sat_flag_q, rxstrobe_q, adc_strobe, cnt_q};

endmodule
